mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Executes MULT/MULTU/DIV/DIVU into the architectural HI/LO registers, and services MTHI/MTLO writes.
- Exposes HI/LO for MFHI/MFLO, and a busy flag the hazard unit uses to stall the pipeline.

---
 rtl/mdu_unit.sv | 137 +++++++++++++
 tb/tb_mdu_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at acceptance and committed after a fixed busy window.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r;
    logic [63:0]    pend_r;
    logic           div0_r;
    logic           busy_r, busy_s;
    logic [31:0]    hi_r, lo_r, hi_s, lo_s;
    logic           accept_s, is_div_s, div0_s, last_s;
    logic           a_neg_s, b_neg_s;
    logic [31:0]    a_mag_s, b_mag_s, b_div_s, quo_s, rem_s, q_s, r_s;
    logic [63:0]    mul_s, mulu_s, result_s;

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Operand decode and arithmetic; divide works on magnitudes so MIN/-1 wraps cleanly.
    always_comb begin
        is_div_s = 1'b0;
        accept_s = 1'b0;
        case (mdu_op)
            OP_MULT, OP_MULTU: accept_s = (state_r == IDLE) && start;
            OP_DIV, OP_DIVU: begin
                is_div_s = 1'b1;
                accept_s = (state_r == IDLE) && start;
            end
            default: accept_s = 1'b0;
        endcase
        div0_s  = is_div_s && (B == 32'd0);
        a_neg_s = (mdu_op == OP_DIV) && A[31];
        b_neg_s = (mdu_op == OP_DIV) && B[31];
        a_mag_s = a_neg_s ? (32'd0 - A) : A;
        b_mag_s = b_neg_s ? (32'd0 - B) : B;
        b_div_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        quo_s   = a_mag_s / b_div_s;
        rem_s   = a_mag_s % b_div_s;
        q_s     = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_s) : quo_s;
        r_s     = a_neg_s ? (32'd0 - rem_s) : rem_s;
        mul_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        mulu_s  = {32'd0, A} * {32'd0, B};
        case (mdu_op)
            OP_MULT:         result_s = mul_s;
            OP_MULTU:        result_s = mulu_s;
            OP_DIV, OP_DIVU: result_s = {r_s, q_s};
            default:         result_s = 64'd0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        last_s  = (cnt_r == CW'(1));
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = IDLE;
                else        state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output logic: MT writes in IDLE, result commit on the last RUN cycle.
    always_comb begin
        hi_s   = hi_r;
        lo_s   = lo_r;
        busy_s = (state_s == RUN);
        if (state_r == IDLE && start && mdu_op == OP_MTHI) begin
            hi_s = A;
        end else if (state_r == IDLE && start && mdu_op == OP_MTLO) begin
            lo_s = A;
        end else if (state_r == RUN && last_s && !div0_r) begin
            hi_s = pend_r[63:32];
            lo_s = pend_r[31:0];
        end else begin
            hi_s = hi_r;
            lo_s = lo_r;
        end
    end

    // State, counter, pending result and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            pend_r  <= 64'd0;
            div0_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            if (accept_s) begin
                pend_r <= result_s;
                div0_r <= div0_s;
                cnt_r  <= is_div_s ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (state_r == RUN) begin
                cnt_r  <= cnt_r - CW'(1);
            end else begin
                cnt_r  <= cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: stimulus pushes expected HI/LO and busy width,
// a negedge monitor pops and compares whenever busy falls.
module tb_mdu_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          width;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   width  = 0;
    logic busy_prev = 1'b0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mdu_op(mdu_op),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int w);
        exp_t e;
        e.hi = h; e.lo = l; e.width = w;
        q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; mdu_op = op; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0; mdu_op = 3'd0;
        A = 32'h5555_AAAA; B = 32'hAAAA_5555;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Scoreboard monitor: compares on every falling edge of busy.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_prev = 1'b0;
            width     = 0;
        end else begin
            if (busy) begin
                width++;
            end else if (busy_prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: hi %h lo %h, required no completion", hi, lo);
                end else begin
                    e = q.pop_front();
                    check("busy_width", width, e.width);
                    check("hi_result", hi, e.hi);
                    check("lo_result", lo, e.lo);
                end
                width = 0;
            end
            busy_prev = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mdu_op = 3'd0; A = 32'd0; B = 32'd0;
        #7;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply signed/unsigned
        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        push(32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle();

        // Divide cases including MIN / -1
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        push(32'd1, 32'd3, 10);
        issue(3'd4, 32'd7, 32'd2);
        wait_idle();
        push(32'd0, 32'h8000_0000, 10);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // MTHI/MTLO preload, then divide by zero leaves HI/LO alone
        issue(3'd5, 32'h1234, 32'd0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h5678, 32'd0);
        @(negedge clk);
        check("mtlo_lo", lo, 32'h5678);
        push(32'h1234, 32'h5678, 10);
        issue(3'd4, 32'd9, 32'd0);
        wait_idle();

        // Starts during RUN are ignored
        push(32'd0, 32'd35, 5);
        issue(3'd1, 32'd5, 32'd7);
        issue(3'd6, 32'hDEAD, 32'd0);
        issue(3'd3, 32'd100, 32'd3);
        wait_idle();
        repeat (12) @(negedge clk);
        check("ignored_busy", {31'd0, busy}, 32'd0);
        check("ignored_lo", lo, 32'd35);

        // Back-to-back: MTHI in first idle cycle
        push(32'd0, 32'd12, 5);
        issue(3'd1, 32'd3, 32'd4);
        wait_idle();
        issue(3'd5, 32'hAA, 32'd0);
        @(negedge clk);
        check("b2b_mthi_hi", hi, 32'hAA);
        check("b2b_mthi_lo", lo, 32'd12);

        // Back-to-back: new MULT in first idle cycle
        push(32'd0, 32'd12, 5);
        issue(3'd1, 32'd3, 32'd4);
        wait_idle();
        push(32'd0, 32'd10, 5);
        issue(3'd1, 32'd2, 32'd5);
        wait_idle();

        // Asynchronous reset in the middle of a divide
        issue(3'd4, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        #10 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("postrst_hi", hi, 32'd0);
        check("postrst_lo", lo, 32'd0);

        check("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
